pe_load_scheduler: RTL
======================

// Module: pe_load_scheduler
// PURPOSE
//  Sequences one convolution PE (dp + main controller) from host-side streams.
//  Latches a job config, fills the filter then IFMap buffers with valid/ready streams, and pulses start.
//  Waits for done, then drains the Psum buffer to a valid/ready output stream and returns to idle.
//  Sits between the system interconnect and the PE top level; owns all PE buffer enables.
// PARAMETERS
//  IFMAP_WIDTH          18  IFMap word width (16 data + 2 flag bits), passed through unchanged
//  FILTER_WIDTH         8   filter word width
//  IFMAP_BUFFER_DEPTH   16  max IFMap words per job
//  FILTER_BUFFER_DEPTH  16  max filter words per job
//  PSUM_DEPTH           8   max Psum words per job
//  FILTER_SIZE_REG_SIZE 8   filter_size width
//  STRIDE_SIZE          3   stride width
//  WDOG_CYCLES          1024  RUN timeout (only with PE_SCHED_WATCHDOG_EN)
// PORTS
//  clk            in   1    clock, rising edge
//  rst            in   1    asynchronous, active-low reset
//  cfg_valid/cfg_ready  in/out 1  job handshake; fields below sampled when both high
//  cfg_stride     in   STRIDE_SIZE            stride for the job
//  cfg_filter_size in  FILTER_SIZE_REG_SIZE   filter words for the job (1..FILTER_BUFFER_DEPTH)
//  cfg_ifmap_words in  $clog2(IFMAP_BUFFER_DEPTH+1)  IFMap words (1..IFMAP_BUFFER_DEPTH)
//  cfg_psum_words in   $clog2(PSUM_DEPTH+1)   Psum words to drain (1..PSUM_DEPTH)
//  flt_valid/flt_ready in/out 1; flt_data in FILTER_WIDTH   host filter stream
//  if_valid/if_ready   in/out 1; if_data  in IFMAP_WIDTH    host IFMap stream
//  pe_stride, pe_filter_size  out  cfg widths  held from the latched config
//  pe_filter_in out FILTER_WIDTH; pe_wen_filter out 1  filter buffer write port
//  pe_ifmap_in  out IFMAP_WIDTH;  pe_wen_ifmap  out 1  IFMap buffer write port
//  pe_start     out  1    one-cycle start pulse
//  pe_chip_en   out  1    high whenever state != IDLE
//  pe_done      in   1    PE done level
//  pe_ren_psum  out  1    Psum buffer read enable; data valid next cycle
//  pe_psum_out  in   IFMAP_WIDTH-2  Psum buffer read data
//  ps_valid/ps_ready out/in 1; ps_data out IFMAP_WIDTH-2  output Psum stream
//  busy out 1 (state != IDLE); err out 1 sticky, cleared on next accepted config
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 except cfg_ready=1; counters and config regs 0.
//  FSM: IDLE -> LOAD_FLT -> LOAD_IF -> START -> RUN -> DRAIN -> IDLE.
//  IDLE: cfg_ready=1; on handshake latch config. Out-of-range field (0 or >depth) -> err=1, stay IDLE.
//  LOAD_FLT: flt_ready=1; each flt handshake -> pe_wen_filter=1, pe_filter_in=flt_data (same cycle, combinational).
//    After cfg_filter_size words -> LOAD_IF. Bubbles (flt_valid=0) are legal and stall.
//  LOAD_IF: same rule with if_* / pe_wen_ifmap for cfg_ifmap_words words. if_ready=0 in all other states.
//  START: pe_start=1 for exactly one cycle -> RUN.
//  RUN: wait for pe_done=1 (first high cycle) -> DRAIN. pe_done already high on entry counts.
//  DRAIN: pe_ren_psum issued only if the output register will be free next cycle
//    (empty, or ps_valid&ps_ready this cycle). Read data loads the register one cycle later.
//    Sustains 1 word/cycle when ps_ready=1. Exactly cfg_psum_words reads issued, never more.
//    -> IDLE when the last word handshakes on ps.
//  ps_data stable while ps_valid & !ps_ready. Latency from last IFMap handshake to pe_start: 1 cycle.
//  Reset mid-job: immediate return to the reset state; no partial pulse on any PE enable.
//  cfg_valid while busy: ignored (cfg_ready=0).
// CONFIGURATION
//  PE_SCHED_WATCHDOG_EN defined: RUN counts cycles. Reaching WDOG_CYCLES without pe_done -> err=1,
//    pe_chip_en drops, -> IDLE without draining. Not defined: RUN waits indefinitely; no counter logic.
// STRUCTURE
//  pe_sched_pkg: state enum pe_sched_state_t, PSUM_W = IFMAP_WIDTH-2 localparam, range-check function.
//  Sub-module psum_skid_reg: one-entry output register with valid/ready, load strobe, full flag.
// TESTING
//  1. cfg{stride=1,filt=3,if=8,psum=6}, streams back-to-back, ps_ready=1
//     -> 3 wen_filter, 8 wen_ifmap, 1 pe_start, 6 ps words equal to the model in order, busy low after.
//  2. Random flt_valid/if_valid bubbles and ps_ready=0 for 5 cycles mid-drain
//     -> no word lost/duplicated; ps_data stable while stalled; exactly 6 pe_ren_psum pulses.
//  3. cfg_filter_size=0 or cfg_ifmap_words=17 -> err=1, state IDLE, no PE enable pulses.
//     Next valid cfg clears err.
//  4. rst low for 1 cycle during LOAD_IF word 4 -> all outputs at reset values.
//     A fresh job then completes normally.
//  5. pe_done already high when RUN is entered -> DRAIN on the next cycle.
//  6. With PE_SCHED_WATCHDOG_EN and WDOG_CYCLES=16, pe_done held low -> err=1 after 16 RUN cycles.
//     IDLE, no pe_ren_psum.

Source files
------------

// File: rtl/pe_load_scheduler_pkg.sv
// Shared types and helpers for the PE load scheduler.
// Imported by pe_load_scheduler and psum_skid_reg.
package pe_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_FLT,
    S_LOAD_IF,
    S_START,
    S_RUN,
    S_DRAIN
  } pe_sched_state_t;

  localparam int unsigned IFMAP_WIDTH_DEF = 18;
  localparam int unsigned PSUM_W          = IFMAP_WIDTH_DEF - 2;

  // A job field is legal when it names at least one word and fits its buffer.
  function automatic logic cfg_in_range(input int unsigned value, input int unsigned depth);
    return (value != 0) && (value <= depth);
  endfunction

endpackage

// File: rtl/pe_load_scheduler_psum_skid_reg.sv
// One-entry Psum output register with valid/ready. A word arriving on the load strobe
// is presented immediately and is only captured if the consumer stalls.
module psum_skid_reg
  import pe_sched_pkg::*;
#(
  parameter int unsigned W = PSUM_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] data,
  output logic         full
);

  logic         reg_full;
  logic [W-1:0] reg_data;

  // The issuer never loads while a stalled word is held, so the two sources are exclusive.
  assign valid = reg_full | load;
  assign data  = reg_full ? reg_data : (load ? load_data : '0);
  assign full  = reg_full;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reg_full <= 1'b0;
      reg_data <= '0;
    end else if (valid && !ready) begin
      reg_full <= 1'b1;
      reg_data <= data;
    end else begin
      reg_full <= 1'b0;
    end
  end

endmodule

// File: rtl/pe_load_scheduler.sv
// Sequences one convolution PE: latch job config, fill filter/IFMap buffers, start, drain Psums.
// Optional RUN timeout enabled by defining PE_SCHED_WATCHDOG_EN.
module pe_load_scheduler
  import pe_sched_pkg::*;
#(
  parameter int unsigned IFMAP_WIDTH          = IFMAP_WIDTH_DEF,
  parameter int unsigned FILTER_WIDTH         = 8,
  parameter int unsigned IFMAP_BUFFER_DEPTH   = 16,
  parameter int unsigned FILTER_BUFFER_DEPTH  = 16,
  parameter int unsigned PSUM_DEPTH           = 8,
  parameter int unsigned FILTER_SIZE_REG_SIZE = 8,
  parameter int unsigned STRIDE_SIZE          = 3
`ifdef PE_SCHED_WATCHDOG_EN
  , parameter int unsigned WDOG_CYCLES        = 1024
`endif
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    cfg_valid,
  output logic                                    cfg_ready,
  input  logic [STRIDE_SIZE-1:0]                  cfg_stride,
  input  logic [FILTER_SIZE_REG_SIZE-1:0]         cfg_filter_size,
  input  logic [$clog2(IFMAP_BUFFER_DEPTH+1)-1:0] cfg_ifmap_words,
  input  logic [$clog2(PSUM_DEPTH+1)-1:0]         cfg_psum_words,
  input  logic                                    flt_valid,
  output logic                                    flt_ready,
  input  logic [FILTER_WIDTH-1:0]                 flt_data,
  input  logic                                    if_valid,
  output logic                                    if_ready,
  input  logic [IFMAP_WIDTH-1:0]                  if_data,
  output logic [STRIDE_SIZE-1:0]                  pe_stride,
  output logic [FILTER_SIZE_REG_SIZE-1:0]         pe_filter_size,
  output logic [FILTER_WIDTH-1:0]                 pe_filter_in,
  output logic                                    pe_wen_filter,
  output logic [IFMAP_WIDTH-1:0]                  pe_ifmap_in,
  output logic                                    pe_wen_ifmap,
  output logic                                    pe_start,
  output logic                                    pe_chip_en,
  input  logic                                    pe_done,
  output logic                                    pe_ren_psum,
  input  logic [IFMAP_WIDTH-3:0]                  pe_psum_out,
  output logic                                    ps_valid,
  input  logic                                    ps_ready,
  output logic [IFMAP_WIDTH-3:0]                  ps_data,
  output logic                                    busy,
  output logic                                    err
);

  localparam int unsigned IFC  = $clog2(IFMAP_BUFFER_DEPTH + 1);
  localparam int unsigned PSC  = $clog2(PSUM_DEPTH + 1);
  localparam int unsigned LD_W = (FILTER_SIZE_REG_SIZE > IFC) ? FILTER_SIZE_REG_SIZE : IFC;

  pe_sched_state_t state, state_n;

  logic [IFC-1:0]  ifw_q;
  logic [PSC-1:0]  psw_q;
  logic [LD_W-1:0] ld_cnt;
  logic [PSC-1:0]  rd_cnt;
  logic [PSC-1:0]  out_cnt;
  logic            ren_d;
  logic            sk_full;
  logic            cfg_ok;
  logic            ld_last;
  logic            ps_pop;
  logic            out_last;
  logic            wdog_hit;

`ifdef PE_SCHED_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(WDOG_CYCLES + 1);
  logic [WD_W-1:0] wdog_cnt;
  assign wdog_hit = (state == S_RUN) && !pe_done && (wdog_cnt == WD_W'(WDOG_CYCLES - 1));
`else
  assign wdog_hit = 1'b0;
`endif

  assign cfg_ok = cfg_in_range(32'(cfg_filter_size), FILTER_BUFFER_DEPTH) &&
                  cfg_in_range(32'(cfg_ifmap_words), IFMAP_BUFFER_DEPTH)  &&
                  cfg_in_range(32'(cfg_psum_words), PSUM_DEPTH);

  assign ld_last  = (state == S_LOAD_FLT) ? (ld_cnt == LD_W'(pe_filter_size) - LD_W'(1))
                                          : (ld_cnt == LD_W'(ifw_q) - LD_W'(1));
  assign ps_pop   = ps_valid && ps_ready;
  assign out_last = (out_cnt == psw_q - PSC'(1));

  assign busy          = (state != S_IDLE);
  assign pe_chip_en    = busy;
  assign pe_wen_filter = flt_valid && flt_ready;
  assign pe_wen_ifmap  = if_valid && if_ready;
  assign pe_filter_in  = pe_wen_filter ? flt_data : '0;
  assign pe_ifmap_in   = pe_wen_ifmap ? if_data : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n     = state;
    cfg_ready   = 1'b0;
    flt_ready   = 1'b0;
    if_ready    = 1'b0;
    pe_start    = 1'b0;
    pe_ren_psum = 1'b0;
    unique case (state)
      S_IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_valid && cfg_ok) state_n = S_LOAD_FLT;
      end
      S_LOAD_FLT: begin
        flt_ready = 1'b1;
        if (flt_valid && ld_last) state_n = S_LOAD_IF;
      end
      S_LOAD_IF: begin
        if_ready = 1'b1;
        if (if_valid && ld_last) state_n = S_START;
      end
      S_START: begin
        pe_start = 1'b1;
        state_n  = S_RUN;
      end
      S_RUN: begin
        if (pe_done)       state_n = S_DRAIN;
        else if (wdog_hit) state_n = S_IDLE;
      end
      S_DRAIN: begin
        // Read only when the output stage is idle next cycle: nothing held or arriving, or a pop now.
        pe_ren_psum = (rd_cnt != psw_q) && (!(sk_full || ren_d) || ps_pop);
        if (ps_pop && out_last) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pe_stride      <= '0;
      pe_filter_size <= '0;
      ifw_q          <= '0;
      psw_q          <= '0;
      ld_cnt         <= '0;
      rd_cnt         <= '0;
      out_cnt        <= '0;
      ren_d          <= 1'b0;
      err            <= 1'b0;
`ifdef PE_SCHED_WATCHDOG_EN
      wdog_cnt       <= '0;
`endif
    end else begin
      ren_d <= pe_ren_psum;
      case (state)
        S_IDLE: begin
          ld_cnt  <= '0;
          rd_cnt  <= '0;
          out_cnt <= '0;
          if (cfg_valid) begin
            err <= !cfg_ok;
            if (cfg_ok) begin
              pe_stride      <= cfg_stride;
              pe_filter_size <= cfg_filter_size;
              ifw_q          <= cfg_ifmap_words;
              psw_q          <= cfg_psum_words;
            end
          end
        end
        S_LOAD_FLT: if (pe_wen_filter) ld_cnt <= ld_last ? '0 : ld_cnt + LD_W'(1);
        S_LOAD_IF:  if (pe_wen_ifmap)  ld_cnt <= ld_last ? '0 : ld_cnt + LD_W'(1);
        S_DRAIN: begin
          if (pe_ren_psum) rd_cnt  <= rd_cnt + PSC'(1);
          if (ps_pop)      out_cnt <= out_cnt + PSC'(1);
        end
        default: ;
      endcase
`ifdef PE_SCHED_WATCHDOG_EN
      if (state == S_START)     wdog_cnt <= '0;
      else if (state == S_RUN)  wdog_cnt <= wdog_cnt + WD_W'(1);
      if (wdog_hit)             err      <= 1'b1;
`endif
    end
  end

  psum_skid_reg #(
    .W (IFMAP_WIDTH - 2)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .load      (ren_d),
    .load_data (pe_psum_out),
    .ready     (ps_ready),
    .valid     (ps_valid),
    .data      (ps_data),
    .full      (sk_full)
  );

endmodule
